pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It takes the 10-bit control word produced by the decoder for the instruction in ID and carries it through ID/EX, EX/MEM and MEM/WB. On the way it inserts bubbles for load-use hazards, flushes on taken branches and jumps, and drains and stops the pipe on `halt`. It drives the PC and IF/ID enables and hands the per-stage EX/MEM/WB control bundles to the datapath.

## Interface
- No parameters.
- `clk  in  1` — rising-edge clock.
- `rst_n  in  1` — asynchronous, active-low reset.
- `id_op  in  6` — opcode in ID; `6'b111111` means halt.
- `id_ctr  in  10` — decoded control word in ID.
  - Bits 9:6 are EX: RegDst, ALUop[1:0], ALUSrc.
  - Bits 5:2 are MEM: jump, Branch, MemRead, MemWrite.
  - Bits 1:0 are WB: RegWrite, MemtoReg.
- `id_rs, id_rt, id_rd  in  5 each` — register fields in ID.
- `ex_br_taken  in  1` — branch condition from the EX comparator. Meaningful only when `ex_ctrl` holds a Branch.
- `ex_ctrl  out  4` — EX bundle held in ID/EX.
- `ex_mem  out  4` — MEM bundle held in ID/EX (jump/Branch used in EX).
- `mem_ctrl  out  4` — MEM bundle held in EX/MEM.
- `wb_ctrl  out  2` — WB bundle held in MEM/WB.
- `ex_wreg, mem_wreg, wb_wreg  out  5 each` — destination register per stage.
- `pc_en  out  1` — PC update enable.
- `ifid_en  out  1` — IF/ID load enable.
- `ifid_flush  out  1` — clear IF/ID to a nop.
- `halted  out  1` — pipe stopped.

## Operation
- **Stage registers**
  - ID/EX captures `id_ctr` plus `id_wreg = id_ctr[9] ? id_rd : id_rt`.
  - EX/MEM captures ID/EX. MEM/WB captures EX/MEM.
  - A bubble is all-zero control with wreg 0.
- **flush** = `ex_mem[3] | (ex_mem[2] & ex_br_taken)`.
  - Effects: `ifid_flush=1`, ID/EX loads a bubble, `pc_en=1` (datapath loads the target).
- **stall** (load-use) = `ex_mem[1] & ex_wreg!=0 & (ex_wreg==id_rs | ex_wreg==id_rt)`, and only when `!flush`.
  - Effects: `pc_en=0`, `ifid_en=0`, ID/EX loads a bubble.
  - EX/MEM and MEM/WB always advance.
- **Priorities:** flush > halt detect > stall. An instruction killed by a flush is never a halt.
- **State machine** (2-bit state, 2-bit drain counter):
  - RUN → DRAIN when `id_op==halt` and `!flush` and `!stall`.
    - On that edge: ID/EX loads a bubble, the counter loads 3.
    - `pc_en=0` and `ifid_en=0` combinationally in the detect cycle.
  - DRAIN: `pc_en=0`, `ifid_en=0`, ID/EX loads bubbles. The counter decrements each cycle.
    - DRAIN → HALTED when the counter is 1. By then the last real instruction has retired from WB.
    - Flush and stall are ignored in DRAIN; a branch in EX at halt detect was already resolved in that cycle.
  - HALTED: `halted=1`, `pc_en=0`, `ifid_en=0`, all stages hold bubbles. Only `rst_n` exits.
- **Outputs in RUN** with no hazard: `pc_en=1`, `ifid_en=1`, `ifid_flush=0`.

## Timing
- **Reset** (async assert, sync release at next edge):
  - All stage control words and wregs are 0. State RUN, counter 0.
  - Outputs: `halted=0`, `pc_en=1`, `ifid_en=1`, `ifid_flush=0`.
- **Latency:** `id_ctr` appears on `ex_ctrl`/`ex_mem` 1 cycle later, on `mem_ctrl` after 2, on `wb_ctrl` after 3.
- **Comb/registered split:**
  - `pc_en`, `ifid_en`, `ifid_flush` are combinational from state and the current inputs.
  - Stage outputs and `halted` are registered.
- **Stall timing:** lasts exactly 1 cycle per lw. The following cycle EX holds a bubble, so the compare clears.
- **Reset mid-DRAIN:** returns to RUN with empty stages; no partial state survives.

## Configuration
- `PIPE_LOADUSE_EN`
  - Defined: load-use stall is active as above.
  - Undefined: stall is forced 0 (the software scheduler inserts nops). Ports are unchanged, and flush/halt behaviour is identical.

## Test plan
- **Straight line:** after reset, feed `addi` (`id_ctr=10'b0001000010`) →
  - same value on `ex_ctrl`/`ex_mem` at +1 cycle;
  - `mem_ctrl=4'b0000` at +2 cycles;
  - `wb_ctrl=2'b10` at +3 cycles.
  - `pc_en=1` throughout.
- **Load-use:** `lw` with rt=5, then `add` with rs=5 →
  - exactly 1 cycle of `pc_en=0`, `ifid_en=0`;
  - `ex_ctrl=0` for that cycle;
  - `add` reaches EX the cycle after.
  - With `PIPE_LOADUSE_EN` undefined: no stall. With lw rt=0: no stall.
- **Taken branch:** Branch in EX with `ex_br_taken=1` → `ifid_flush=1` for 1 cycle and the next `ex_ctrl=0`. With `ex_br_taken=0` there is no flush.
- **Jump vs halt:** jump in EX while `id_op=6'b111111` →
  - flush wins and state stays RUN;
  - a later unflushed halt gives `halted=1` exactly 4 edges after detect, with `pc_en=0` from the detect cycle onward.
- **Stall vs flush:** lw in EX matching the ID operand while a flush condition is asserted → flush behaviour only, `pc_en=1`.
- **Reset mid-DRAIN:** assert `rst_n=0` 2 cycles into DRAIN → immediately all stage outputs 0 and `halted=0`; RUN resumes after release.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the 5-stage MIPS core.
//   Carries the decoded control word through ID/EX, EX/MEM and MEM/WB,
//   inserting bubbles for load-use hazards, flushing on taken branches/jumps,
//   and draining then stopping the pipe on halt.
//   Inputs : clk, rst_n (async active-low), id_op, id_ctr, id_rs/id_rt/id_rd,
//            ex_br_taken.
//   Outputs: ex_ctrl/ex_mem (ID/EX), mem_ctrl (EX/MEM), wb_ctrl (MEM/WB),
//            ex_wreg/mem_wreg/wb_wreg, pc_en, ifid_en, ifid_flush, halted.
//   Build option: define PIPE_LOADUSE_EN to enable the load-use stall;
//   otherwise the software scheduler is trusted to insert nops.
module pipe_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] id_op,
  input  logic [9:0] id_ctr,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       ex_br_taken,
  output logic [3:0] ex_ctrl,
  output logic [3:0] ex_mem,
  output logic [3:0] mem_ctrl,
  output logic [1:0] wb_ctrl,
  output logic [4:0] ex_wreg,
  output logic [4:0] mem_wreg,
  output logic [4:0] wb_wreg,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       halted
);
`ifdef PIPE_LOADUSE_EN
  localparam logic LU_EN = 1'b1;
`else
  localparam logic LU_EN = 1'b0;
`endif
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic [9:0] idex_c, exmem_c, memwb_c;
  logic [4:0] idex_w, exmem_w, memwb_w;
  logic run, flush, load_use, stall, halt_det, bubble;
  assign run      = state == RUN;
  // jump or taken branch sitting in EX kills the instruction in ID
  assign flush    = run & (idex_c[5] | (idex_c[4] & ex_br_taken));
  assign load_use = idex_c[3] & |idex_w & (idex_w == id_rs | idex_w == id_rt);
  assign stall    = LU_EN & run & ~flush & load_use;
  // a flushed instruction is never a halt
  assign halt_det = run & (id_op == 6'h3f) & ~flush & ~stall;
  assign bubble   = ~run | flush | stall | halt_det;
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pc_en      = run & ~stall & ~halt_det;
    ifid_en    = run & ~stall & ~halt_det;
    ifid_flush = flush;
    if (halt_det) begin
      state_nx = DRAIN;
      cnt_nx   = 2'd3;
    end else if (state == DRAIN) begin
      cnt_nx = cnt - 2'd1;
      if (cnt == 2'd1) state_nx = HALTED;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      cnt     <= 2'd0;
      idex_c  <= '0;
      idex_w  <= '0;
      exmem_c <= '0;
      exmem_w <= '0;
      memwb_c <= '0;
      memwb_w <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      idex_c  <= bubble ? 10'd0 : id_ctr;
      idex_w  <= bubble ? 5'd0 : (id_ctr[9] ? id_rd : id_rt);
      exmem_c <= idex_c;
      exmem_w <= idex_w;
      memwb_c <= exmem_c;
      memwb_w <= exmem_w;
    end
  end
  assign ex_ctrl  = idex_c[9:6];
  assign ex_mem   = idex_c[5:2];
  assign mem_ctrl = exmem_c[5:2];
  assign wb_ctrl  = memwb_c[1:0];
  assign ex_wreg  = idex_w;
  assign mem_wreg = exmem_w;
  assign wb_wreg  = memwb_w;
  assign halted   = state == HALTED;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table, directed and random checks of pipe_ctrl against a stage-list model.
module tb_pipe_ctrl;
`ifdef PIPE_LOADUSE_EN
  localparam bit LU = 1'b1;
`else
  localparam bit LU = 1'b0;
`endif
  localparam logic [9:0] ADDI = 10'h042, LW = 10'h04B, ADD = 10'h302, BEQ = 10'h090, JMP = 10'h020;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [5:0] id_op;
  logic [9:0] id_ctr;
  logic [4:0] id_rs, id_rt, id_rd;
  logic ex_br_taken;
  logic [3:0] ex_ctrl, ex_mem, mem_ctrl;
  logic [1:0] wb_ctrl;
  logic [4:0] ex_wreg, mem_wreg, wb_wreg;
  logic pc_en, ifid_en, ifid_flush, halted;
  int vecs = 0, errs = 0;
  pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_ctr(id_ctr), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .ex_br_taken(ex_br_taken), .ex_ctrl(ex_ctrl),
    .ex_mem(ex_mem), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .ex_wreg(ex_wreg),
    .mem_wreg(mem_wreg), .wb_wreg(wb_wreg), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .halted(halted)
  );
  always #5 clk = ~clk;
  // reference: list of in-flight instructions (0=EX,1=MEM,2=WB) plus edges since halt
  typedef struct packed {logic [9:0] c; logic [4:0] w;} stg_t;
  stg_t m [3];
  int since;
  bit e_run, e_fl, e_st, e_h;
  typedef struct {
    logic [5:0] op; logic [9:0] c; logic [4:0] rs, rt, rd; logic br;
    logic pc, ife, fl; logic [3:0] exc, exm, memc; logic [1:0] wbc;
  } vec_t;
  vec_t tbl [13];
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic mreset();
    for (int i = 0; i < 3; i++) m[i] = '0;
    since = 0;
  endtask
  task automatic calc();
    e_run = since == 0;
    e_fl  = e_run && (m[0].c[5] || (m[0].c[4] && ex_br_taken));
    e_st  = LU && e_run && !e_fl && m[0].c[3] && m[0].w != 0 && (m[0].w == id_rs || m[0].w == id_rt);
    e_h   = e_run && id_op == 6'd63 && !e_fl && !e_st;
  endtask
  task automatic mcheck();
    calc();
    chk("pc_en", pc_en, e_run && !e_st && !e_h);
    chk("ifid_en", ifid_en, e_run && !e_st && !e_h);
    chk("ifid_flush", ifid_flush, e_fl);
    chk("ex_ctrl", ex_ctrl, m[0].c[9:6]);
    chk("ex_mem", ex_mem, m[0].c[5:2]);
    chk("mem_ctrl", mem_ctrl, m[1].c[5:2]);
    chk("wb_ctrl", wb_ctrl, m[2].c[1:0]);
    chk("ex_wreg", ex_wreg, m[0].w);
    chk("mem_wreg", mem_wreg, m[1].w);
    chk("wb_wreg", wb_wreg, m[2].w);
    chk("halted", halted, since >= 4);
  endtask
  task automatic mupdate();
    calc();
    m[2] = m[1];
    m[1] = m[0];
    m[0] = (e_run && !e_fl && !e_st && !e_h) ? {id_ctr, id_ctr[9] ? id_rd : id_rt} : '0;
    if (e_h) since = 1;
    else if (since > 0 && since < 4) since++;
  endtask
  task automatic drv(input logic [5:0] op, input logic [9:0] c, input logic [4:0] rs, rt, rd, input logic br);
    id_op = op; id_ctr = c; id_rs = rs; id_rt = rt; id_rd = rd; ex_br_taken = br;
  endtask
  task automatic cyc(input logic [5:0] op, input logic [9:0] c, input logic [4:0] rs, rt, rd, input logic br);
    drv(op, c, rs, rt, rd, br);
    @(negedge clk);
    mcheck();
  endtask
  task automatic adv();
    @(posedge clk);
    mupdate();
    #1;
  endtask
  task automatic nop();
    cyc(0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    mreset();
    chk("rst ex_ctrl", ex_ctrl, 0);
    chk("rst ex_mem", ex_mem, 0);
    chk("rst mem_ctrl", mem_ctrl, 0);
    chk("rst wb_ctrl", wb_ctrl, 0);
    chk("rst wregs", {ex_wreg, mem_wreg, wb_wreg}, 0);
    chk("rst halted", halted, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    logic [9:0] pool [6];
    pool = '{ADDI, LW, ADD, BEQ, JMP, 10'h000};
    tbl[0]  = '{8, ADDI, 1, 2, 3, 0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'b00};
    tbl[1]  = '{0, 0,    0, 0, 0, 0, 1, 1, 0, 4'b0001, 4'b0000, 4'b0000, 2'b00};
    tbl[2]  = '{0, 0,    0, 0, 0, 0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'b00};
    tbl[3]  = '{0, 0,    0, 0, 0, 0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'b10};
    tbl[4]  = '{4, BEQ,  1, 2, 0, 0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'b00};
    tbl[5]  = '{8, ADDI, 1, 2, 3, 1, 1, 1, 1, 4'b0010, 4'b0100, 4'b0000, 2'b00};
    tbl[6]  = '{0, 0,    0, 0, 0, 0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0100, 2'b00};
    tbl[7]  = '{4, BEQ,  1, 2, 0, 0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'b00};
    tbl[8]  = '{8, ADDI, 1, 2, 3, 0, 1, 1, 0, 4'b0010, 4'b0100, 4'b0000, 2'b00};
    tbl[9]  = '{0, 0,    0, 0, 0, 0, 1, 1, 0, 4'b0001, 4'b0000, 4'b0100, 2'b00};
    tbl[10] = '{2, JMP,  0, 0, 0, 0, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'b00};
    tbl[11] = '{63, 0,   0, 0, 0, 0, 1, 1, 1, 4'b0000, 4'b1000, 4'b0000, 2'b10};
    tbl[12] = '{0, 0,    0, 0, 0, 0, 1, 1, 0, 4'b0000, 4'b0000, 4'b1000, 2'b00};
    drv(0, 0, 0, 0, 0, 0);
    #2;
    do_reset();
    // straight line, taken/untaken branch, jump beating halt
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].op, tbl[i].c, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].br);
      chk($sformatf("tbl%0d pc_en", i), pc_en, tbl[i].pc);
      chk($sformatf("tbl%0d ifid_en", i), ifid_en, tbl[i].ife);
      chk($sformatf("tbl%0d ifid_flush", i), ifid_flush, tbl[i].fl);
      chk($sformatf("tbl%0d stages", i), {ex_ctrl, ex_mem, mem_ctrl, wb_ctrl},
          {tbl[i].exc, tbl[i].exm, tbl[i].memc, tbl[i].wbc});
      adv();
    end
    // unflushed halt: pc_en low from detect, halted exactly 4 edges later
    cyc(63, 0, 0, 0, 0, 0);
    chk("halt detect pc_en", pc_en, 0);
    chk("halt detect ifid_en", ifid_en, 0);
    adv();
    for (int k = 1; k <= 5; k++) begin
      nop();
      chk($sformatf("drain%0d halted", k), halted, k >= 4);
      chk($sformatf("drain%0d pc_en", k), pc_en, 0);
      adv();
    end
    // load-use
    do_reset();
    cyc(35, LW, 1, 5, 0, 0);
    adv();
    cyc(0, ADD, 5, 6, 7, 0);
    chk("lu pc_en", pc_en, !LU);
    chk("lu ifid_en", ifid_en, !LU);
    chk("lu ex_ctrl lw", ex_ctrl, 4'b0001);
    adv();
`ifdef PIPE_LOADUSE_EN
    cyc(0, ADD, 5, 6, 7, 0);
    chk("lu bubble ex_ctrl", ex_ctrl, 0);
    chk("lu after pc_en", pc_en, 1);
    adv();
`endif
    nop();
    chk("lu add in EX", ex_ctrl, 4'b1100);
    chk("lu add wreg", ex_wreg, 7);
    adv();
    // lw writing r0 never stalls
    cyc(35, LW, 1, 0, 0, 0);
    adv();
    cyc(0, ADD, 0, 0, 7, 0);
    chk("lw r0 pc_en", pc_en, 1);
    adv();
    // load-use against a simultaneous flush: flush only
    cyc(35, LW | 10'h010, 1, 5, 0, 0);
    adv();
    cyc(0, ADD, 5, 6, 7, 1);
    chk("st+fl pc_en", pc_en, 1);
    chk("st+fl ifid_flush", ifid_flush, 1);
    adv();
    nop();
    chk("st+fl ex_ctrl", ex_ctrl, 0);
    adv();
    // reset two cycles into drain
    do_reset();
    cyc(8, ADDI, 1, 2, 3, 0); adv();
    cyc(8, ADDI, 1, 4, 3, 0); adv();
    cyc(63, 0, 0, 0, 0, 0); adv();
    nop(); adv();
    nop();
    chk("pre-rst wb_ctrl", wb_ctrl, 2'b10);
    #1;
    do_reset();
    chk("post-rst pc_en", pc_en, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(8, ADDI, 1, 2, 3, 0);
      adv();
    end
    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [9:0] c;
      logic [5:0] op;
      if ((since >= 4 && $urandom_range(3) == 0) || $urandom_range(299) == 0) do_reset();
      c = pool[$urandom_range(5)];
      if ($urandom_range(7) == 0) c = 10'($urandom);
      op = ($urandom_range(24) == 0) ? 6'd63 : 6'($urandom_range(62));
      cyc(op, c, 5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom));
      adv();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
